// File: rtl/core_boot_pkg.sv
// Shared types for the core boot/run sequencer.
package core_boot_pkg;

  localparam int OUT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/core_boot_ctrl_if.sv
// Program-stream handshake from the host into the boot controller.
interface core_boot_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              prog_ready;

  modport master (output prog_valid, prog_data, prog_last, input prog_ready);
  modport slave  (input prog_valid, prog_data, prog_last, output prog_ready);
endinterface

// File: rtl/core_halt_detect.sv
// Flags halt once core_out has matched its previous value STABLE_CYC times in a row.
// halt is combinational in the cycle of the final matching comparison; no backpressure.
module core_halt_detect
  import core_boot_pkg::*;
#(
  parameter int STABLE_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OUT_W-1:0] core_out,
  output logic             halt
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  logic             armed_q, armed_d;
  logic [OUT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same;

  // The first enabled cycle only primes prev; comparisons start on the next one.
  always_comb begin
    same    = (core_out == prev_q);
    halt    = en && armed_q && same && (cnt_q == CNT_W'(STABLE_CYC - 1));
    armed_d = en;
    prev_d  = en ? core_out : prev_q;
    cnt_d   = '0;
    if (en && armed_q && same) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot sequencer: streams a program into imem, holds the core in reset, runs it until halt/watchdog.
// imem write lands on the handshake edge; prog_ready is high for the whole LOAD state.
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RESET_HOLD = 4,
  parameter int STABLE_CYC = 8,
  parameter int WDOG_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  core_boot_ctrl_if.slave     prog,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_wdata,
  output logic                core_reset,
  input  logic [OUT_W-1:0]    core_out,
  output logic [OUT_W-1:0]    result,
  output logic                result_valid,
  output logic                err,
  output logic                busy,
  output logic [WDOG_W-1:0]   run_cycles
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               rvld_q, rvld_d;
  logic               err_q, err_d;
  logic [WDOG_W-1:0]  run_q, run_d;
  logic [WDOG_W-1:0]  run_inc;
  logic               accept;
  logic               halt;

  core_halt_detect #(.STABLE_CYC(STABLE_CYC)) u_halt (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_RUN),
    .core_out (core_out),
    .halt     (halt)
  );

  assign prog.prog_ready = (state_q == ST_LOAD);
  assign accept          = prog.prog_valid && (state_q == ST_LOAD);
  assign imem_we         = accept;
  assign imem_addr       = addr_q;
  assign imem_wdata      = prog.prog_data;
  assign core_reset      = (state_q != ST_RUN);
  assign busy            = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign result          = result_q;
  assign result_valid    = rvld_q;
  assign err             = err_q;
  assign run_cycles      = run_q;
  assign run_inc         = run_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    result_d = result_q;
    rvld_d   = rvld_q;
    err_d    = err_q;
    run_d    = run_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          err_d   = 1'b0;
          rvld_d  = 1'b0;
          run_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // The address saturates at the top word so an overflowing load never wraps.
          if (addr_q != ADDR_MAX) begin
            addr_d = addr_q + 1'b1;
          end
          if (prog.prog_last) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else if (addr_q == ADDR_MAX) begin
            state_d  = ST_DONE;
            err_d    = 1'b1;
            rvld_d   = 1'b1;
            result_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        run_d = run_inc;
        // Halt takes priority over a watchdog expiry landing on the same cycle.
        if (halt) begin
          state_d  = ST_DONE;
          result_d = core_out;
          err_d    = 1'b0;
          rvld_d   = 1'b1;
        end else if (&run_inc) begin
          state_d  = ST_DONE;
          result_d = core_out;
          err_d    = 1'b1;
          rvld_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      hold_q   <= '0;
      result_q <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hold_q   <= hold_d;
      result_q <= result_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl with imem-write and run-result scoreboards.
module tb_core_boot_ctrl;
  import core_boot_pkg::*;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int RESET_HOLD = 4;
  localparam int STABLE_CYC = 8;
  localparam int WDOG_W     = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [OUT_W-1:0]  res;
    logic              err;
    logic [WDOG_W-1:0] cyc;
  } res_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_reset;
  logic [OUT_W-1:0]  core_out;
  logic [OUT_W-1:0]  result;
  logic              result_valid;
  logic              err;
  logic              busy;
  logic [WDOG_W-1:0] run_cycles;

  logic [DATA_W-1:0] words [32];
  wr_t  wr_q  [$];
  res_t res_q [$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_wr   = 0;

  core_boot_ctrl_if #(.DATA_W(DATA_W)) prog_if ();

  core_boot_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_HOLD(RESET_HOLD),
    .STABLE_CYC(STABLE_CYC), .WDOG_W(WDOG_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog         (prog_if),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .core_out     (core_out),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .busy         (busy),
    .run_cycles   (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // imem writes are popped from the scoreboard as the DUT issues them.
  always @(negedge clk) begin : imem_mon
    wr_t e;
    if (reset === 1'b0 && imem_we === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) begin
        check("imem_unexpected_we", imem_we, 1'b0);
      end else begin
        e = wr_q.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("imem_wdata", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // A start pulse in the first gap slot must be ignored while loading.
  task automatic load(input int n, input int gap, input bit with_last);
    int w;
    for (int i = 0; i < n; i++) begin
      prog_if.prog_valid = 1'b1;
      prog_if.prog_data  = words[i];
      prog_if.prog_last  = with_last && (i == n - 1);
      wr_q.push_back(wr_t'{addr: ADDR_W'(i), data: words[i]});
      w = 0;
      while (prog_if.prog_ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (w == 20) check("prog_ready_timeout", prog_if.prog_ready, 1'b1);
      tick();
      prog_if.prog_valid = 1'b0;
      prog_if.prog_last  = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = (g == 0);
          tick();
          start = 1'b0;
          check("gap_no_we", imem_we, 1'b0);
        end
      end
    end
  endtask

  task automatic measure_hold();
    int h;
    h = 0;
    while (core_reset === 1'b1 && h < 20) begin
      tick();
      h++;
    end
    check("reset_hold_cycles", h, RESET_HOLD);
  endtask

  // mode 0: ramp 1,2,3 then hold 45; mode 1: alternate every cycle.
  task automatic run_core(input int mode, input int max_cyc);
    int k;
    k = 0;
    while (result_valid !== 1'b1 && k < max_cyc) begin
      if (mode == 0) core_out = (k < 3) ? OUT_W'(k + 1) : OUT_W'(45);
      else           core_out = k[0] ? 10'h2AA : 10'h155;
      if (k == 0) check("core_released", core_reset, 1'b0);
      tick();
      k++;
    end
    check("run_done_seen", result_valid, 1'b1);
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (res_q.size() == 0) begin
      check({tag, "_unexpected"}, result_valid, 1'b0);
      return;
    end
    e = res_q.pop_front();
    check({tag, "_result"}, result, e.res);
    check({tag, "_valid"}, result_valid, 1'b1);
    check({tag, "_err"}, err, e.err);
    check({tag, "_run_cycles"}, run_cycles, e.cyc);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int wr0;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'hFFDF_F06F;
    for (int i = 3; i < 32; i++) words[i] = 32'hA5000000 | i * 32'h0001_0101;

    reset = 1'b1;
    start = 1'b0;
    prog_if.prog_valid = 1'b0;
    prog_if.prog_data  = '0;
    prog_if.prog_last  = 1'b0;
    core_out = '0;
    tick();
    tick();
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_prog_ready", prog_if.prog_ready, 1'b0);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_run_cycles", run_cycles, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // Continuous load of three words, then halt on a stable 45.
    pulse_start();
    check("load_busy", busy, 1'b1);
    check("load_ready", prog_if.prog_ready, 1'b1);
    load(3, 0, 1'b1);
    check("load_writes", n_wr, 3);
    measure_hold();
    res_q.push_back(res_t'{res: OUT_W'(45), err: 1'b0, cyc: WDOG_W'(3 + 1 + STABLE_CYC)});
    run_core(0, 200);
    check_result("halt");

    // Restart from DONE with gapped words, then run into the watchdog.
    pulse_start();
    check("restart_valid_clr", result_valid, 1'b0);
    check("restart_err_clr", err, 1'b0);
    check("restart_addr", imem_addr, 0);
    load(3, 2, 1'b1);
    check("gap_writes", n_wr, 6);
    measure_hold();
    res_q.push_back(res_t'{res: 10'h155, err: 1'b1, cyc: WDOG_W'((1 << WDOG_W) - 1)});
    run_core(1, 200);
    check_result("wdog");

    // Overflow: 32 words without a last marker.
    wr0 = n_wr;
    pulse_start();
    load(32, 0, 1'b0);
    check("ovf_writes", n_wr - wr0, 32);
    check("ovf_addr_nowrap", imem_addr, 31);
    check("ovf_ready", prog_if.prog_ready, 1'b0);
    res_q.push_back(res_t'{res: '0, err: 1'b1, cyc: '0});
    check_result("ovf");

    // Reset mid-run, then a clean reload.
    pulse_start();
    load(3, 0, 1'b1);
    measure_hold();
    for (int i = 0; i < 3; i++) begin
      core_out = OUT_W'(100 + i);
      tick();
    end
    check("midrun_released", core_reset, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_core_reset", core_reset, 1'b1);
    check("mrst_result_valid", result_valid, 1'b0);
    check("mrst_err", err, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_run_cycles", run_cycles, 0);
    check("mrst_result", result, 0);
    check("mrst_imem_addr", imem_addr, 0);
    tick();
    check("mrst_stays_idle", busy, 1'b0);
    pulse_start();
    load(3, 0, 1'b1);
    measure_hold();
    res_q.push_back(res_t'{res: OUT_W'(45), err: 1'b0, cyc: WDOG_W'(3 + 1 + STABLE_CYC)});
    run_core(0, 200);
    check_result("rerun");
    check("wr_queue_drained", wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_boot_ctrl.md
Name: core_boot_ctrl

Overview:
Boot and run sequencer for the single-cycle RISC-V core (clk, reset, out[9:0]).
- Holds the core in reset while it streams a program into instruction memory over a valid/ready port.
- Releases the core after a fixed reset-hold window, then watches the core's 10-bit out bus.
- Run ends when out has settled (halt) or a watchdog expires. The final value is presented to the host with a valid flag.
- Sits between the host/testbench side and the core top level, replacing hand-timed reset pulses.

Parameters:
- ADDR_W, 5, imem address width; depth = 2**ADDR_W words.
- DATA_W, 32, instruction word width.
- RESET_HOLD, 4, cycles core_reset stays high after load completes (>=1).
- STABLE_CYC, 8, consecutive unchanged core_out comparisons that define halt (>=1).
- WDOG_W, 16, watchdog/cycle counter width; timeout at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; all state cleared on the edge where it is sampled high.
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE.
- prog_valid  in  1  program word valid.
- prog_data  in  DATA_W  program word.
- prog_last  in  1  marks the final word; qualified by prog_valid.
- prog_ready  out  1  controller accepts a word.
- imem_we  out  1  imem write enable.
- imem_addr  out  ADDR_W  imem write address.
- imem_wdata  out  DATA_W  imem write data.
- core_reset  out  1  active-high reset to the core.
- core_out  in  10  core observation bus.
- result  out  10  captured core_out at end of run.
- result_valid  out  1  result is valid.
- err  out  1  overflow or watchdog timeout.
- busy  out  1  high in LOAD, HOLD, RUN.
- run_cycles  out  WDOG_W  cycles spent in RUN.

Behaviour:
- Reset values:
  - State IDLE, core_reset=1, prog_ready=0, imem_we=0.
  - imem_addr=0, result=0, result_valid=0, err=0, busy=0, run_cycles=0, all internal counters 0.
  - Reset in any state, including mid-LOAD or mid-RUN, aborts immediately; no partial result is presented.
- FSM states: IDLE, LOAD, HOLD, RUN, DONE. core_reset=1 in every state except RUN.
- IDLE:
  - prog_ready=0.
  - start -> LOAD; clears addr, err, result_valid, run_cycles.
- LOAD:
  - prog_ready=1.
  - imem_we = prog_valid & prog_ready (combinational), imem_addr = addr reg, imem_wdata = prog_data. The write takes effect on the same edge as the handshake.
  - Each accepted word increments addr by 1.
  - An accepted word with prog_last -> HOLD next cycle.
  - Accepted word at addr = 2**ADDR_W-1 without prog_last:
    - The word is written.
    - err=1 and state -> DONE with result=0; addr does not wrap.
  - prog_valid gaps are allowed; no timeout in LOAD.
  - start is ignored in LOAD.
- HOLD:
  - prog_ready=0.
  - Counts exactly RESET_HOLD cycles, then -> RUN.
- RUN:
  - core_reset=0; run_cycles increments every RUN cycle.
  - core_out is registered into prev each cycle.
  - On the first RUN cycle, prev is loaded and no comparison is made.
  - Each following cycle: stable_cnt increments if core_out==prev, else resets to 0.
  - When stable_cnt reaches STABLE_CYC -> DONE, result=core_out, err=0.
  - If run_cycles reaches all-ones before that -> DONE, result=core_out, err=1.
  - If both occur on the same cycle, the halt wins and err=0.
- DONE:
  - core_reset=1; result, result_valid=1, err and run_cycles are held.
  - start -> LOAD: clears result_valid and err, addr=0.
- busy = state in {LOAD, HOLD, RUN}.

Decomposition:
- Package core_boot_pkg: state enum (IDLE/LOAD/HOLD/RUN/DONE) and the OUT_W=10 constant.
- One natural sub-module: core_halt_detect (prev register, stable counter, halt pulse), parameterised by STABLE_CYC.

Test Plan:
- Load 3 words 0x00000013, 0x00100093, 0xFFDFF06F (last on the 3rd), prog_valid continuous -> imem writes addr 0,1,2 on consecutive cycles; core_reset stays high exactly 4 cycles after the last write, then drops.
- Backpressure: insert a 2-cycle prog_valid gap between words -> no imem_we during the gap; addresses remain contiguous 0,1,2.
- Halt: after release, core_out counts up, then holds 45 -> after 8 equal comparisons: result=45, result_valid=1, err=0, core_reset=1, busy=0.
- Watchdog: WDOG_W=6, core_out toggling every cycle -> DONE after 63 RUN cycles; err=1, result = last core_out.
- Overflow: 32 words with no prog_last -> all 32 are written; err=1, result_valid=1, state DONE, HOLD/RUN never entered.
- Reset mid-RUN, then start again -> core_reset=1 on the next cycle and outputs at reset values; a subsequent start reloads from addr 0 and completes normally.
